// File: rtl/sar_search_ctrl_pkg.sv
// Shared definitions for the successive-approximation search controller.
package sar_search_ctrl_pkg;

  // Default operand width; a search takes at most this many TEST cycles.
  localparam int SAR_WIDTH_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    TEST = 1'b1
  } sar_state_t;

endpackage

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives a trial operand into a
// magnitude comparator and resolves the unknown operand MSB-first.
module sar_search_ctrl
  import sar_search_ctrl_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             a_gt_b,
  input  logic             a_lt_b,
  input  logic             a_eq_b,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             error
);

  // Index needs at least one bit even for a degenerate 1-bit search.
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

  sar_state_t       state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] decided;   // trial with the current bit resolved
  logic [WIDTH-1:0] next_trial; // decided plus the next lower bit set
  logic             flags_ok;
  logic             eq_only;
  logic             lt_only;

  // Classify the comparator response; anything not one-hot is treated as gt.
  always_comb begin
    flags_ok   = ({a_gt_b, a_lt_b, a_eq_b} == 3'b100) ||
                 ({a_gt_b, a_lt_b, a_eq_b} == 3'b010) ||
                 ({a_gt_b, a_lt_b, a_eq_b} == 3'b001);
    eq_only    = flags_ok && a_eq_b;
    lt_only    = flags_ok && a_lt_b;
    decided    = trial;
    if (lt_only) decided[idx] = 1'b0;
    next_trial = decided;
    if (idx != '0) next_trial[idx - 1'b1] = 1'b1;
  end

  // Search FSM with registered trial, index, result and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      trial  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      error  <= 1'b0;
      idx    <= IDX_MSB;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            trial <= {1'b1, {(WIDTH-1){1'b0}}};
            idx   <= IDX_MSB;
            error <= 1'b0;
            busy  <= 1'b1;
            state <= TEST;
          end
        end
        TEST: begin
          if (!flags_ok) error <= 1'b1;
          if (eq_only) begin
            // Exact hit: stop early with the current trial.
            result <= trial;
            done   <= 1'b1;
            trial  <= '0;
            busy   <= 1'b0;
            idx    <= IDX_MSB;
            state  <= IDLE;
          end else if (idx == '0) begin
            result <= decided;
            done   <= 1'b1;
            trial  <= '0;
            busy   <= 1'b0;
            idx    <= IDX_MSB;
            state  <= IDLE;
          end else begin
            trial <= next_trial;
            idx   <= idx - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Randomized scoreboard bench for sar_search_ctrl with a behavioural comparator.
module tb_sar_search_ctrl;

  localparam int W = 4;

  typedef struct {
    int res;
    int err;
    int n;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         a_gt_b, a_lt_b, a_eq_b;
  logic [W-1:0] trial, result;
  logic         busy, done, error;

  logic [W-1:0] unknown = '0;
  logic         force_en = 1'b0;
  logic [2:0]   force_flags = 3'b000; // {gt, lt, eq}

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Comparator on the bench side; flags can be overridden for fault cases.
  assign a_gt_b = force_en ? force_flags[2] : (unknown > trial);
  assign a_lt_b = force_en ? force_flags[1] : (unknown < trial);
  assign a_eq_b = force_en ? force_flags[0] : (unknown == trial);

  sar_search_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_gt_b(a_gt_b), .a_lt_b(a_lt_b), .a_eq_b(a_eq_b),
    .trial(trial), .busy(busy), .done(done), .result(result), .error(error)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: binary search over bit weights, with one optionally forced answer.
  function automatic exp_t model(input int unk, input int fcyc, input int ff);
    exp_t e;
    int   known;
    int   guess;
    int   resp;
    known = 0;
    e.err = 0;
    e.n   = W;
    for (int b = W - 1; b >= 0; b--) begin
      guess = known + (1 << b);
      if (W - b == fcyc) resp = ff;
      else resp = (unk > guess) ? 4 : (unk < guess) ? 2 : 1;
      if (resp == 1) begin
        e.res = guess;
        e.n   = W - b;
        return e;
      end
      if (resp != 2) begin
        if (resp != 4) e.err = 1;
        known = guess;
      end
    end
    e.res = known;
    return e;
  endfunction

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    cyc++;
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", int'(result), e.res);
        chk("error", int'(error), e.err);
        chk("latency", cyc - start_cyc, e.n + 1);
        chk("busy_at_done", int'(busy), 0);
        chk("trial_at_done", int'(trial), 0);
      end
    end
    if (rst_n && start && !busy) start_cyc = cyc;
  end

  // Called inside TEST cycle 1; steps cycles until done or the bound expires.
  task automatic wait_done(input int fcyc, input int ff, input bit midstart);
    bit seen;
    seen = 1'b0;
    for (int c = 1; c <= W + 2; c++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      force_en    = (c == fcyc);
      force_flags = 3'(ff);
      start       = midstart && (c == 2);
      @(posedge clk); #1;
    end
    force_en = 1'b0;
    start    = 1'b0;
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic run(input int unk, input int fcyc, input int ff, input bit midstart);
    unknown = W'(unk);
    sb.push_back(model(unk, fcyc, ff));
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(fcyc, ff, midstart);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_trial", int'(trial), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_error", int'(error), 0);

    // Directed searches.
    run(11, 0, 0, 1'b0);
    run(8, 0, 0, 1'b0);
    run(0, 0, 0, 1'b0);
    run(15, 0, 0, 1'b0);
    run(5, 2, 0, 1'b0);
    chk("error_sticky", int'(error), 1);
    @(posedge clk); #1;
    chk("error_held", int'(error), 1);

    // Reset in the second TEST cycle aborts the search.
    unknown = 4'd6;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    chk("abort_trial", int'(trial), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_result", int'(result), 0);
    chk("abort_done", int'(done), 0);
    repeat (4) @(posedge clk);
    #1;
    run(3, 0, 0, 1'b0);

    // start while busy is ignored.
    run(0, 0, 0, 1'b1);
    run(9, 0, 0, 1'b1);

    // Back-to-back: start during the done cycle.
    run(6, 0, 0, 1'b0);
    unknown = 4'd13;
    sb.push_back(model(13, 0, 0));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", int'(busy), 1);
    wait_done(0, 0, 1'b0);

    // Randomized searches, some with a forced flag pattern.
    for (int i = 0; i < 40; i++) begin
      int u, fc, ff;
      u  = int'($urandom_range(0, 15));
      fc = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, W)) : 0;
      ff = int'($urandom_range(0, 7));
      run(u, fc, ff, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
